// File: rtl/register_shift_sipo_deserializer_pkg.sv
// Shared definitions for the 4-bit serial link (SIPO/PISO).
// State encoding and default word width.
package register_shift_pkg;

  localparam int REG_SHIFT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/register_shift_sipo_deserializer_if.sv
// Serial-side inputs and parallel-side outputs of the SIPO.
// master drives serial side, slave is the deserializer.
interface register_shift_sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             clear;
  logic             shift_en;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             busy;
  logic             parity_err;

  modport master (
    output clear, shift_en, serial_in,
    input  parallel_out, out_valid, busy, parity_err
  );

  modport slave (
    input  clear, shift_en, serial_in,
    output parallel_out, out_valid, busy, parity_err
  );
endinterface

// File: rtl/register_shift_sipo_deserializer_bit_counter.sv
// Mod-MOD bit counter with enable and sync clear.
// tc flags the enabled edge that finishes a frame.
module sipo_bit_counter #(
  parameter int MOD = 4,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = en && (cnt == CW'(MOD - 1));

  // count enabled bits, wrap to 0 at the frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/register_shift_sipo_deserializer.sv
// Serial-in/parallel-out receiver, MSB first.
// Optional even parity bit per word: define SIPO_PARITY_EN.
module register_shift_sipo_deserializer
  import register_shift_pkg::*;
#(
  parameter int WIDTH = REG_SHIFT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  register_shift_sipo_deserializer_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SIPO_PARITY_EN
  localparam int MOD = WIDTH + 1;
`else
  localparam int MOD = WIDTH;
`endif

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] word_nxt;
  logic [WIDTH-1:0] par_q;
  logic             vld_q;
  logic             perr_q;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             last_bit;
  logic             shift_ok;
  logic             done;

  sipo_bit_counter #(
    .MOD (MOD),
    .CW  (CW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .en    (bus.shift_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign done     = tc && !bus.clear;

`ifdef SIPO_PARITY_EN
  assign shift_ok = bus.shift_en && (state != S_PARITY);
  assign word_nxt = shift_reg;
`else
  assign shift_ok = bus.shift_en;
  assign word_nxt = {shift_reg[WIDTH-2:0], bus.serial_in};
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state: clear wins over a bit in the same cycle
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = S_IDLE;
    end else if (bus.shift_en) begin
      case (state)
        S_IDLE:   state_nxt = S_SHIFT;
`ifdef SIPO_PARITY_EN
        S_SHIFT:  if (last_bit) state_nxt = S_PARITY;
`else
        S_SHIFT:  if (last_bit) state_nxt = S_IDLE;
`endif
        S_PARITY: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // data bits shift in MSB first; parity bit is not stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (bus.clear) begin
      shift_reg <= '0;
    end else if (shift_ok) begin
      shift_reg <= {shift_reg[WIDTH-2:0], bus.serial_in};
    end
  end

  // publish the finished word with a one-cycle strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= '0;
      vld_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      vld_q <= done;
      if (done) begin
        par_q <= word_nxt;
`ifdef SIPO_PARITY_EN
        perr_q <= ^{shift_reg, bus.serial_in};
`endif
      end
    end
  end

  assign bus.parallel_out = par_q;
  assign bus.out_valid    = vld_q;
  assign bus.parity_err   = perr_q;
  assign bus.busy         = (cnt != '0);

endmodule

// File: tb/tb_register_shift_sipo_deserializer.sv
// Randomized + directed bench for the SIPO deserializer.
// Scoreboard queue fed by a bit-list model, drained by a monitor.
module tb_register_shift_sipo_deserializer;
  import register_shift_pkg::*;

  localparam int W = REG_SHIFT_WIDTH;
`ifdef SIPO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  register_shift_sipo_deserializer_if #(.WIDTH(W)) bus ();

  register_shift_sipo_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] word;
    logic         perr;
  } exp_t;

  exp_t exp_q[$];
  bit   bits[$];
  logic [W-1:0] m_word = '0;
  logic m_perr = 1'b0;
  logic m_pulse = 1'b0;
  logic prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // reference: a list of received bits, a word is complete at NB bits
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits.delete();
      m_word  = '0;
      m_perr  = 1'b0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (bus.clear) begin
        bits.delete();
      end else if (bus.shift_en) begin
        bits.push_back(bus.serial_in);
        if (bits.size() == NB) begin
          int v;
          int ones;
          exp_t e;
          v = 0;
          ones = 0;
          for (int i = 0; i < W; i++) v = v * 2 + int'(bits[i]);
          for (int i = 0; i < NB; i++) ones += int'(bits[i]);
          m_word = W'(v);
`ifdef SIPO_PARITY_EN
          m_perr = (ones % 2) == 1;
`else
          m_perr = 1'b0;
`endif
          m_pulse = 1'b1;
          e.word = m_word;
          e.perr = m_perr;
          exp_q.push_back(e);
          bits.delete();
        end
      end
    end
  end

  // monitor on the falling edge
  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(m_pulse));
    chk("busy", 32'(bus.busy), 32'(bits.size() != 0));
    chk("parallel_out", 32'(bus.parallel_out), 32'(m_word));
    chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
    if (prev_vld) chk("pulse_width", 32'(bus.out_valid), 32'd0);
    prev_vld = bus.out_valid;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_word", 32'(bus.parallel_out), 32'(e.word));
        chk("sb_perr", 32'(bus.parity_err), 32'(e.perr));
      end
    end
  end

  task automatic drive(input logic se, input logic si, input logic cl);
    bus.shift_en  = se;
    bus.serial_in = si;
    bus.clear     = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0);
  endtask

  task automatic send_p(input logic [W-1:0] w, input logic p);
    send(w);
`ifdef SIPO_PARITY_EN
    drive(1'b1, p, 1'b0);
`else
    if (p === 1'bx) drive(1'b0, 1'b0, 1'b0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.shift_en  = 1'b0;
    bus.serial_in = 1'b0;
    bus.clear     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_par", 32'(bus.parallel_out), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: single word, strobe one cycle after the last bit
    send_p(4'b1101, 1'b1);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_word", 32'(bus.parallel_out), 32'hd);
    idle(1);
    chk("t1_pulse_off", 32'(bus.out_valid), 32'd0);
    idle(2);

    // 2: back to back
    send_p(4'b1101, 1'b1);
    chk("t2_word_a", 32'(bus.parallel_out), 32'hd);
    send_p(4'b0110, 1'b0);
    chk("t2_word_b", 32'(bus.parallel_out), 32'h6);
    idle(2);

    // 3: gap inside a word
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    idle(3);
    chk("t3_busy_gap", 32'(bus.busy), 32'd1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    drive(1'b1, 1'b1, 1'b0);
`endif
    chk("t3_word", 32'(bus.parallel_out), 32'hd);
    idle(2);

    // 4: clear aborts a partial word
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    chk("t4_busy_clr", 32'(bus.busy), 32'd0);
    send_p(4'b1010, 1'b0);
    chk("t4_word", 32'(bus.parallel_out), 32'ha);
    idle(2);

    // 5: reset mid-word
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_par", 32'(bus.parallel_out), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_p(4'b0011, 1'b0);
    chk("t5_word", 32'(bus.parallel_out), 32'h3);
    idle(2);

`ifdef SIPO_PARITY_EN
    // 6: parity good then bad
    send_p(4'b1101, 1'b1);
    chk("t6_perr_ok", 32'(bus.parity_err), 32'd0);
    send_p(4'b1101, 1'b0);
    chk("t6_perr_bad", 32'(bus.parity_err), 32'd1);
    idle(3);
    chk("t6_perr_hold", 32'(bus.parity_err), 32'd1);
`endif

    // random traffic with gaps, clears and rare resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 24) == 0);
    end
    idle(NB + 3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
